// File: rtl/lau_pkg.sv
// lau_pkg: shared types and helpers for the arithmetic unit library.
//   speed_e        - performance selector for prefix networks (SLOW = ripple,
//                    FAST = logarithmic-depth prefix tree)
//   serial_state_e - handshake FSM states shared by the digit-serial units
//   serial_digits  - number of digits a serial unit walks through
//   serial_cnt_width - width of the digit counter for those units
package lau_pkg;

  typedef enum logic {
    SLOW,
    FAST
  } speed_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } serial_state_e;

  function automatic int serial_digits(input int width, input int dwidth);
    return width / dwidth;
  endfunction

  // A single-digit unit still needs a 1-bit counter so the port never
  // collapses to zero width.
  function automatic int serial_cnt_width(input int width, input int dwidth);
    int n;
    n = width / dwidth;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/PrefixAndOr.sv
// PrefixAndOr: inclusive prefix network over (generate, propagate) pairs.
//   GI, PI : per-bit generate / propagate inputs
//   GO, PO : group generate / propagate from bit 0 up to each bit
// speed selects a ripple chain (SLOW) or a Kogge-Stone tree (FAST).
module PrefixAndOr
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] GI,
  input  logic [width-1:0] PI,
  output logic [width-1:0] GO,
  output logic [width-1:0] PO
);

  localparam int levels = (width > 1) ? $clog2(width) : 0;

  logic [width-1:0] g, p, gn, pn;

  always_comb begin
    g  = GI;
    p  = PI;
    gn = '0;
    pn = '0;
    if (speed == SLOW) begin
      for (int i = 1; i < width; i++) begin
        g[i] = GI[i] | (PI[i] & g[i-1]);
        p[i] = PI[i] & p[i-1];
      end
    end else begin
      // Each level combines a bit with the one 2^l positions below it.
      for (int l = 0; l < levels; l++) begin
        gn = g;
        pn = p;
        for (int i = (1 << l); i < width; i++) begin
          gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
          pn[i] = p[i] & p[i-(1<<l)];
        end
        g = gn;
        p = pn;
      end
    end
    GO = g;
    PO = p;
  end

endmodule

// File: rtl/add_cv_digit.sv
// add_cv_digit: combinational dwidth-bit adder slice for the serial adder.
//   a, b : digit operands
//   ci   : carry into the digit LSB
//   s    : digit sum
//   co   : carry out of the digit MSB
//   cmsb : carry into the digit MSB (used for signed overflow)
module add_cv_digit
  import lau_pkg::*;
#(
  parameter int     dwidth = 8,
  parameter speed_e speed  = FAST
) (
  input  logic [dwidth-1:0] a,
  input  logic [dwidth-1:0] b,
  input  logic              ci,
  output logic [dwidth-1:0] s,
  output logic              co,
  output logic              cmsb
);

  logic [dwidth-1:0] gi, pi, pt, go, po;
  logic [dwidth:0]   c;

  // OR-propagate is enough for carries; XOR-propagate is kept for the sum.
  assign gi = a & b;
  assign pi = a | b;
  assign pt = a ^ b;

  PrefixAndOr #(
    .width(dwidth),
    .speed(speed)
  ) u_prefix (
    .GI(gi),
    .PI(pi),
    .GO(go),
    .PO(po)
  );

  // Carry into bit j is the group carry of bits [j-1:0] with ci folded in.
  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int j = 1; j <= dwidth; j++) begin
      c[j] = go[j-1] | (po[j-1] & ci);
    end
  end

  assign s    = pt ^ c[dwidth-1:0];
  assign co   = c[dwidth];
  assign cmsb = c[dwidth-1];

endmodule

// File: rtl/add_cv_serial.sv
// add_cv_serial: digit-serial two's-complement adder, S = A + B + CI.
// One dwidth-bit digit is added per cycle, LSB first, with the carry kept
// in a register between digits.
//   CLK, RSTn          - clock (rising edge), async active-low reset
//   InValid / InReady  - operand handshake (A, B, CI)
//   OutValid / OutReady- result handshake (S, CO, V)
//   S  - registered sum, CO - unsigned carry out, V - signed overflow
module add_cv_serial
  import lau_pkg::*;
#(
  parameter int     width  = 32,
  parameter int     dwidth = 8,
  parameter speed_e speed  = FAST
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             InValid,
  output logic             InReady,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [width-1:0] S,
  output logic             CO,
  output logic             V
);

  localparam int n  = serial_digits(width, dwidth);
  localparam int cw = serial_cnt_width(width, dwidth);

  if (dwidth < 1 || (width % dwidth) != 0) begin : g_param_check
    $error("add_cv_serial: width must be a positive multiple of dwidth");
  end

  serial_state_e     state_q, state_d;
  logic [cw-1:0]     cnt_q;
  logic              carry_q;
  logic [width-1:0]  a_q, b_q, s_q, s_next;
  logic              co_q, v_q;
  logic [dwidth-1:0] a_dig, b_dig, dsum;
  logic              dco, dcmsb;
  logic              last;

  assign last = (cnt_q == cw'(n - 1));

  // Select the current digit of each operand and build the sum with the
  // new digit merged in; the counter never leaves 0..n-1.
  always_comb begin
    a_dig  = '0;
    b_dig  = '0;
    s_next = s_q;
    for (int d = 0; d < n; d++) begin
      if (cnt_q == cw'(d)) begin
        a_dig = a_q[d*dwidth +: dwidth];
        b_dig = b_q[d*dwidth +: dwidth];
        s_next[d*dwidth +: dwidth] = dsum;
      end
    end
  end

  add_cv_digit #(
    .dwidth(dwidth),
    .speed (speed)
  ) u_digit (
    .a   (a_dig),
    .b   (b_dig),
    .ci  (carry_q),
    .s   (dsum),
    .co  (dco),
    .cmsb(dcmsb)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (InValid)  state_d = CALC;
      CALC:    if (last)     state_d = DONE;
      DONE:    if (OutReady) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operands are only sampled on accept, so they need no reset.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && InValid) begin
      a_q <= A;
      b_q <= B;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (InValid) begin
            carry_q <= CI;
            cnt_q   <= '0;
          end
        end
        CALC: begin
          s_q     <= s_next;
          carry_q <= dco;
          if (last) begin
            co_q <= dco;
            v_q  <= dco ^ dcmsb;
          end else begin
            cnt_q <= cnt_q + cw'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign S        = s_q;
  assign CO       = co_q;
  assign V        = v_q;

endmodule
